// File: rtl/prbs4_checker.sv
// prbs4_checker
//
// Serial PRBS-4 receive checker. A local 4-bit generator is seeded from the
// first four valid bits of the incoming stream. After that, the generator
// predicts every bit using b[n] = b[n-3] ^ b[n-4], which is a maximal-length
// sequence with a period of 15. Each received bit is compared with the
// prediction. Mismatches are reported and counted. Too many mismatches inside
// one 15-bit window drop lock, and the checker then re-seeds.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   in_bit is consumed this cycle
//   in_bit     in   received serial bit
//   clear      in   synchronous clear of err_count (wins over an increment)
//   locked     out  local generator is synchronised
//   err_pulse  out  one-cycle pulse per mismatched bit
//   err_count  out  saturating count of mismatches seen while locked
//
// All outputs are registered.

module prbs4_checker #(
  parameter int ERR_W       = 8,
  parameter int LOSS_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [0:0] {
    SEED   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};
  localparam logic [4:0]       THRESH_C = 5'(LOSS_THRESH);

  state_e           state_q, state_d;
  logic [1:0]       seed_cnt_q, seed_cnt_d;
  // Only the three most recent bits are stored. The fourth seed bit is
  // taken directly from in_bit on the edge that completes the seed.
  logic [2:0]       h_q, h_d;
  logic [3:0]       g_q, g_d;
  logic [3:0]       win_cnt_q, win_cnt_d;
  logic [3:0]       win_err_q, win_err_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic             exp_bit_s;
  logic             mismatch_s;
  logic [3:0]       seed_s;
  logic [4:0]       win_err_sum_s;

  // Next-state logic: seeding, prediction, window accounting and error count.
  always_comb begin
    state_d       = state_q;
    seed_cnt_d    = seed_cnt_q;
    h_d           = h_q;
    g_d           = g_q;
    win_cnt_d     = win_cnt_q;
    win_err_d     = win_err_q;
    err_count_d   = err_count_q;
    err_pulse_d   = 1'b0;
    exp_bit_s     = g_q[2] ^ g_q[3];
    seed_s        = {h_q, in_bit};
    mismatch_s    = 1'b0;
    win_err_sum_s = 5'd0;

    if (in_valid) begin
      case (state_q)
        SEED: begin
          h_d = {h_q[1:0], in_bit};
          if (seed_cnt_q == 2'd3) begin
            seed_cnt_d = 2'd0;
            // An all-zero seed is the lock-up state of the generator and is rejected.
            if (seed_s != 4'd0) begin
              g_d       = seed_s;
              state_d   = LOCKED;
              win_cnt_d = 4'd0;
              win_err_d = 4'd0;
            end else begin
              state_d = SEED;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + 2'd1;
          end
        end

        LOCKED: begin
          // The prediction never uses in_bit, so a bit error does not propagate.
          g_d           = {g_q[2:0], exp_bit_s};
          mismatch_s    = in_bit ^ exp_bit_s;
          err_pulse_d   = mismatch_s;
          win_err_sum_s = {1'b0, win_err_q} + {4'd0, mismatch_s};

          if (mismatch_s && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_ONE;
          end else begin
            err_count_d = err_count_q;
          end

          // Loss of lock takes priority over the window-end wrap.
          if (win_err_sum_s >= THRESH_C) begin
            state_d    = SEED;
            seed_cnt_d = 2'd0;
            win_cnt_d  = 4'd0;
            win_err_d  = 4'd0;
          end else if (win_cnt_q == 4'd14) begin
            win_cnt_d = 4'd0;
            win_err_d = 4'd0;
          end else begin
            win_cnt_d = win_cnt_q + 4'd1;
            win_err_d = win_err_sum_s[3:0];
          end
        end

        default: begin
          state_d    = SEED;
          seed_cnt_d = 2'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (clear) begin
      err_count_d = ERR_ZERO;
    end else begin
      err_count_d = err_count_d;
    end

    locked_d = (state_d == LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEED;
      seed_cnt_q  <= 2'd0;
      h_q         <= 3'd0;
      g_q         <= 4'd0;
      win_cnt_q   <= 4'd0;
      win_err_q   <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= ERR_ZERO;
    end else begin
      state_q     <= state_d;
      seed_cnt_q  <= seed_cnt_d;
      h_q         <= h_d;
      g_q         <= g_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: doc/prbs4_checker.md
# prbs4_checker

Serial PRBS-4 receiver/checker: the receive end of the 4-bit LFSR stream used across the design. It self-synchronises a local 4-bit LFSR to an incoming bit stream with recurrence b[n] = b[n-3] XOR b[n-4], a maximal-length sequence with period 15. After lock it compares every received bit against its own prediction, counts mismatches and drops lock on excessive errors. It sits after an LFSR-based source or link and gives loopback and link-integrity status.

## Interface
- ERR_W, 8: width of the saturating error counter; 4..16.
- LOSS_THRESH, 4: mismatches within one 15-bit window that force loss of lock; 1..15.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_bit is consumed on this cycle.
- in_bit  in  1  received serial bit; b[n] is the n-th valid bit.
- clear  in  1  synchronous clear of err_count.
- locked  out  1  the local LFSR is synchronised.
- err_pulse  out  1  one-cycle pulse per mismatched bit.
- err_count  out  ERR_W  total mismatches while locked; saturates at all-ones.

## Operation
- States:
  - SEED: collect 4 bits into history h[3:0]. Shift on each valid bit: h <= {h[2:0], in_bit}. seed_cnt counts 0..3.
  - LOCKED: local generator g[3:0] predicts the stream.
- Reset state: SEED, seed_cnt=0, h=0, g=0, window counters 0. Outputs: locked=0, err_pulse=0, err_count=0.
- SEED, on the 4th valid bit (seed_cnt==3), the candidate seed is {h[2:0], in_bit}:
  - Nonzero seed: load g with it, go to LOCKED, clear window counters.
  - Seed 0000: this is the LFSR lock-up state. Stay in SEED with seed_cnt=0.
- LOCKED, on each valid bit:
  - Expected bit e = g[2] XOR g[3]. Update g <= {g[2:0], e}.
  - The prediction never uses in_bit, so bit errors do not propagate.
  - mismatch = in_bit XOR e.
- Window logic:
  - win_cnt counts 0..14 over valid bits in LOCKED. win_err counts mismatches in the current window.
  - After the bit with win_cnt==14, both counters return to 0.
  - If win_err + mismatch reaches LOSS_THRESH: go to SEED, seed_cnt=0, window counters cleared. This takes priority over the window-end wrap.
  - The bit that causes the loss is not used as a seed bit.
- err_count:
  - Increments by 1 per mismatch in LOCKED and holds at 2^ERR_W-1.
  - It is kept across loss of lock; only rst or clear zeroes it.
  - clear wins over a simultaneous increment.
- in_valid=0: no state, counter or history changes. err_pulse is 0 on the next cycle.
- A mismatch on the bit that forces loss of lock still pulses err_pulse and still counts.

## Timing
- All outputs are registered. Nothing is combinational from the inputs.
- locked rises on the cycle after the edge that accepts the 4th nonzero seed bit. Minimum acquisition is 4 valid bits.
- err_pulse is high for exactly the one cycle after the edge that accepts the mismatched bit.
- err_count updates on that same edge, so it is visible together with err_pulse.
- locked falls on the cycle after the edge that accepts the threshold-reaching bit.
- in_valid may toggle every cycle; back-to-back valid bits give back-to-back err_pulse cycles.
- rst asserted mid-operation returns to the reset state on the next edge, whatever the inputs are.
- clear has one-cycle latency: err_count reads 0 on the cycle after clear is sampled.

## Test plan
- Clean stream: after rst, send 1,0,0,0,1,0,0,1,1,0,1,0,1,1,1 repeated for 45 valid bits, with in_valid=1 every cycle.
  - locked=1 from the cycle after the 4th bit.
  - err_pulse never asserts; err_count=0.
- Single error: locked clean stream, invert one bit.
  - Exactly one err_pulse, one cycle after that bit; err_count=1; locked stays 1.
  - The following bits produce no further pulses.
- All-zero seed: send 8 zeros, then 1,0,0,0.
  - locked stays 0 through the zeros and rises after the 1,0,0,0 group.
- Loss of lock (LOSS_THRESH=4): invert 4 bits within one 15-bit window.
  - 4 err_pulses; err_count=4.
  - locked falls the cycle after the 4th inverted bit, then relocks 4 valid bits later.
  - Inverting 3 bits per window indefinitely never drops lock.
- Gapped valid with saturation (ERR_W=4): in_valid=1 every third cycle, with the stream fully inverted after lock.
  - Every mismatch counts; err_count stops at 15 and does not wrap.
- clear and rst races:
  - clear coincident with a mismatch gives err_count=0, err_pulse=1.
  - rst mid-stream gives locked=0 and err_count=0 on the next cycle.
  - Relock follows after 4 valid bits.
